// File: rtl/shift_pkg.sv
// Shared types for the shift-command path: the command record that travels
// from producers through shift_cmd_fifo into barrel_shifter_8bit.
package shift_pkg;

    localparam int SHIFT_DATA_W = 8;
    localparam int SHIFT_AMT_W  = 3;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] data;
        logic [SHIFT_AMT_W-1:0]  amt;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo_mem.sv
// Command storage: DEPTH entries, one synchronous write port and one
// asynchronous read port so the head can feed the shifter combinationally.
module shift_cmd_fifo_mem
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  shift_cmd_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output shift_cmd_t       rdata
);

    // Contents are intentionally not reset; validity is tracked by the count.
    shift_cmd_t mem [DEPTH];

    // Write the accepted command into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/shift_cmd_fifo.sv
// First-word-fall-through command FIFO placed ahead of barrel_shifter_8bit.
// The head entry drives the shifter data/ctrl directly; in_ready depends only
// on registered state so there is no combinational path from out_ready.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int AMT_W  = SHIFT_AMT_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_ctrl,
    output logic [PTR_W:0]    count,
    output logic              ovf,
    input  logic              clr_ovf
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt_q;
    logic             ovf_q;
    logic             push;
    logic             pop;
    shift_cmd_t       wr_cmd;
    shift_cmd_t       rd_cmd;

    // Full blocks new writes even when a pop happens the same cycle.
    assign in_ready  = !rst && (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;
    assign ovf       = ovf_q;

    assign wr_cmd.data = in_data;
    assign wr_cmd.amt  = in_amt;

    shift_cmd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_cmd),
        .raddr (rd_ptr),
        .rdata (rd_cmd)
    );

    // Head is only visible when valid and outside reset; stale slots read as zero.
    always_comb begin
        out_data = '0;
        out_ctrl = '0;
        if (out_valid && !rst) begin
            out_data = rd_cmd.data;
            out_ctrl = rd_cmd.amt;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (PTR_W+1)'(1);
            end
        end
    end

    // Sticky overflow: a rejected write sets it, and setting beats clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Bench for shift_cmd_fifo: a queue-based model checked every cycle, plus
// hand-computed literal expectations (including the shifted result data>>amt).
module tb_shift_cmd_fifo;
    import shift_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic [2:0]       in_amt = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [2:0]       out_ctrl;
    logic [PTR_W:0]   count;
    logic             ovf;
    logic             clr_ovf = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    shift_cmd_t q[$];
    logic       m_ovf = 1'b0;
    logic       chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_cmd_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update from the rules: accept when not full, pop when non-empty.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            chk_en = 1'b1;
        end else begin
            automatic bit full = (q.size() == DEPTH);
            automatic bit do_push = in_valid && !full;
            automatic bit do_pop = (q.size() != 0) && out_ready;
            automatic shift_cmd_t c;
            c.data = in_data;
            c.amt  = in_amt;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(c);
            if (in_valid && full) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Compare process: all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
                chk("rst_out_data", {21'b0, out_data, out_ctrl}, 32'd0);
            end else begin
                chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() != DEPTH});
                chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
                chk("count", {29'b0, count}, q.size());
                chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
                if (q.size() != 0) begin
                    chk("out_data", {24'b0, out_data}, {24'b0, q[0].data});
                    chk("out_ctrl", {29'b0, out_ctrl}, {29'b0, q[0].amt});
                end else begin
                    chk("out_idle", {21'b0, out_data, out_ctrl}, 32'd0);
                end
            end
            chk("count_le_depth", {31'b0, count <= (PTR_W+1)'(DEPTH)}, 32'd1);
        end
    end

    // One cycle of stimulus; results are visible 1 time unit after the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic [2:0] a,
                        input logic ordy, input logic clr);
        in_valid  = iv;
        in_data   = d;
        in_amt    = a;
        out_ready = ordy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] shout();
        return out_data >> out_ctrl;
    endfunction

    logic [7:0] fd [4] = '{8'h81, 8'hF0, 8'hFF, 8'h3C};
    logic [2:0] fa [4] = '{3'd1, 3'd4, 3'd7, 3'd0};
    logic [7:0] fs [4] = '{8'h40, 8'h0F, 8'h01, 8'h3C};

    initial begin
        // 1. reset and first push
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_count", {29'b0, count}, 32'd0);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_rst_ovf", {31'b0, ovf}, 32'd0);
        step(1, 8'hB4, 3'd2, 0, 0);
        chk("fwft_valid", {31'b0, out_valid}, 32'd1);
        chk("fwft_data", {24'b0, out_data}, 32'h0B4);
        chk("fwft_ctrl", {29'b0, out_ctrl}, 32'd2);
        chk("fwft_shift", {24'b0, shout()}, 32'h02D);
        step(0, 0, 0, 1, 0);

        // 2. fill and drain
        for (int i = 0; i < 4; i++) step(1, fd[i], fa[i], 0, 0);
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_shift", {24'b0, shout()}, {24'b0, fs[i]});
            step(0, 0, 0, 1, 0);
        end
        chk("drain_count", {29'b0, count}, 32'd0);

        // 3. overflow at full
        for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 3'(i), 0, 0);
        step(1, 8'hEE, 3'd1, 1, 0);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        chk("ovf_count", {29'b0, count}, 32'd3);
        step(1, 8'h55, 3'd3, 0, 0);
        step(1, 8'h66, 3'd2, 0, 1);
        chk("ovf_set_wins", {31'b0, ovf}, 32'd1);
        step(0, 0, 0, 0, 1);
        chk("ovf_cleared", {31'b0, ovf}, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // 4. sustained traffic at count=2 across pointer wraps
        step(1, 8'hA5, 3'd1, 0, 0);
        step(1, 8'h5A, 3'd2, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(i * 37 + 3), 3'(i), 1, 0);
            chk("steady_count", {29'b0, count}, 32'd2);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // 5. reset with three queued
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 3'd1, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_count", {29'b0, count}, 32'd0);
        step(1, 8'h80, 3'd7, 0, 0);
        chk("post_rst_data", {24'b0, out_data}, 32'h080);
        chk("post_rst_shift", {24'b0, shout()}, 32'h001);
        step(0, 0, 0, 1, 0);

        // 6. empty pops, then random traffic
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("empty_pop_count", {29'b0, count}, 32'd0);
        step(1, 8'h99, 3'd5, 0, 0);
        chk("after_empty_pop_data", {24'b0, out_data}, 32'h099);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0);
        chk("final_count", {29'b0, count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
